// File: rtl/timer_ctrl_master.sv
// timer_ctrl_master: Avalon-MM initiator that programs a 16-bit interval timer,
// services its timeouts by polling status (optionally kicked by timer_irq),
// and turns each serviced timeout into a one-cycle tick pulse.
module timer_ctrl_master #(
    parameter int POLL_GAP = 16,
    parameter int USE_IRQ  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] period,
    input  logic        continuous,
    input  logic        irq_en,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic        busy,
    output logic        cfg_err,
    output logic [2:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [15:0] av_writedata,
    input  logic [15:0] av_readdata,
    input  logic        timer_irq
);

    // Timer register map and control words
    localparam logic [2:0]  REG_STATUS   = 3'd0;
    localparam logic [2:0]  REG_CONTROL  = 3'd1;
    localparam logic [2:0]  REG_PERIOD_L = 3'd2;
    localparam logic [2:0]  REG_PERIOD_H = 3'd3;
    localparam logic [15:0] CTRL_STOP    = 16'h0008;
    localparam logic [15:0] GAP_LAST     = 16'(POLL_GAP - 1);

    typedef enum logic [3:0] {
        IDLE,
        WR_STOP,
        WR_PERL,
        WR_PERH,
        WR_CTRL,
        RUN_WAIT,
        RD_STAT,
        STAT_CHK,
        WR_CLR,
        WR_HALT
    } state_t;

    state_t      state, next_state;
    logic [31:0] period_q;
    logic        cont_q;
    logic        irq_en_q;
    logic [15:0] gap_cnt;
    logic        stop_pend;
    logic [15:0] tick_cnt_q;

    logic        stop_req;
    logic        stop_eff;
    logic        start_ok;
    logic        start_bad;
    logic        irq_kick;

    logic        cs_d;
    logic        wn_d;
    logic [2:0]  addr_d;
    logic [15:0] wdata_d;

    // Only timeout (bit0) and running (bit1) matter; the rest are reserved
    logic [13:0] stat_unused;
    assign stat_unused = av_readdata[15:2];

    assign tick_count = tick_cnt_q;
    assign busy       = (state != IDLE);

    // Request qualification: stop beats start, and stop only counts while active
    always_comb begin
        stop_req  = stop && (state != IDLE) && (state != WR_HALT);
        stop_eff  = stop_req || stop_pend;
        start_ok  = (state == IDLE) && start && !stop && (period != 32'd0);
        start_bad = (state == IDLE) && start && !stop && (period == 32'd0);
        irq_kick  = (USE_IRQ != 0) && timer_irq;
    end

    // Next-state logic; a stop lets the current access finish, and a timeout
    // already seen in STAT_CHK is still cleared (and ticked) before halting
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start_ok) next_state = WR_STOP;
            WR_STOP:  next_state = stop_eff ? WR_HALT : WR_PERL;
            WR_PERL:  next_state = stop_eff ? WR_HALT : WR_PERH;
            WR_PERH:  next_state = stop_eff ? WR_HALT : WR_CTRL;
            WR_CTRL:  next_state = stop_eff ? WR_HALT : RUN_WAIT;
            RUN_WAIT: begin
                if (stop_eff)
                    next_state = WR_HALT;
                else if (irq_kick || (gap_cnt == GAP_LAST))
                    next_state = RD_STAT;
            end
            // Read data only arrives next cycle, so always go check it
            RD_STAT:  next_state = STAT_CHK;
            STAT_CHK: begin
                if (av_readdata[0])
                    next_state = WR_CLR;
                else if (stop_eff)
                    next_state = WR_HALT;
                else if (av_readdata[1])
                    next_state = RUN_WAIT;
                else
                    next_state = IDLE;
            end
            WR_CLR: begin
                if (stop_eff)
                    next_state = WR_HALT;
                else if (cont_q)
                    next_state = RUN_WAIT;
                else
                    next_state = IDLE;
            end
            WR_HALT:  next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Bus access for the state being entered, so the registered bus lines up
    // with the state it belongs to
    always_comb begin
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = REG_STATUS;
        wdata_d = 16'h0000;
        case (next_state)
            WR_STOP, WR_HALT: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = REG_CONTROL;
                wdata_d = CTRL_STOP;
            end
            WR_PERL: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = REG_PERIOD_L;
                wdata_d = period_q[15:0];
            end
            WR_PERH: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = REG_PERIOD_H;
                wdata_d = period_q[31:16];
            end
            WR_CTRL: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = REG_CONTROL;
                wdata_d = {12'h000, 1'b0, 1'b1, cont_q, irq_en_q};
            end
            RD_STAT: begin
                cs_d    = 1'b1;
                addr_d  = REG_STATUS;
            end
            WR_CLR: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = REG_STATUS;
            end
            default: ;
        endcase
    end

    // State register and poll-gap counter (restarts on every RUN_WAIT entry)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            gap_cnt <= 16'h0000;
        end else begin
            state   <= next_state;
            gap_cnt <= ((state == RUN_WAIT) && (next_state == RUN_WAIT)) ? gap_cnt + 16'h0001 : 16'h0000;
        end
    end

    // Configuration latched on an accepted start; stop remembered until halted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q  <= 32'h0;
            cont_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            if (start_ok) begin
                period_q <= period;
                cont_q   <= continuous;
                irq_en_q <= irq_en;
            end
            stop_pend <= stop_eff && (next_state != WR_HALT) && (next_state != IDLE);
        end
    end

    // Tick pulse, tick counter and config-error pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick       <= 1'b0;
            tick_cnt_q <= 16'h0000;
            cfg_err    <= 1'b0;
        end else begin
            tick    <= (next_state == WR_CLR);
            cfg_err <= start_bad;
            if (start_ok)
                tick_cnt_q <= 16'h0000;
            else if (next_state == WR_CLR)
                tick_cnt_q <= tick_cnt_q + 16'h0001;
        end
    end

    // Registered Avalon outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            av_address    <= 3'd0;
            av_writedata  <= 16'h0000;
        end else begin
            av_chipselect <= cs_d;
            av_write_n    <= wn_d;
            av_address    <= addr_d;
            av_writedata  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Directed bench for timer_ctrl_master: the bench plays the timer slave's
// status register and checks bus traffic, tick, tick_count, busy and cfg_err.
module tb_timer_ctrl_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] period = 32'h0;
    logic        continuous = 1'b0;
    logic        irq_en = 1'b0;
    logic        tick;
    logic [15:0] tick_count;
    logic        busy;
    logic        cfg_err;
    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata = 16'h0;
    logic        timer_irq = 1'b0;

    logic [15:0] stat_val = 16'h0;
    int          checks = 0;
    int          errors = 0;

    localparam logic [20:0] BUS_IDLE = {1'b0, 1'b1, 3'd0, 16'h0000};
    localparam logic [20:0] BUS_RD   = {1'b1, 1'b1, 3'd0, 16'h0000};

    logic [20:0] bus_obs;
    assign bus_obs = {av_chipselect, av_write_n, av_address, av_writedata};

    timer_ctrl_master #(.POLL_GAP(16), .USE_IRQ(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .period(period), .continuous(continuous), .irq_en(irq_en),
        .tick(tick), .tick_count(tick_count), .busy(busy), .cfg_err(cfg_err),
        .av_address(av_address), .av_chipselect(av_chipselect),
        .av_write_n(av_write_n), .av_writedata(av_writedata),
        .av_readdata(av_readdata), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    // Slave status register: registered read data one cycle after the read
    always @(posedge clk)
        av_readdata <= (av_chipselect && av_write_n && av_address == 3'd0) ? stat_val : 16'h0000;

    function automatic logic [20:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {1'b1, 1'b0, a, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [31:0] p, input logic c, input logic ie);
        period = p; continuous = c; irq_en = ie; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_read(input string tag, input int max, output int n);
        n = 0;
        while (bus_obs !== BUS_RD && n < max) begin
            cyc();
            n++;
        end
        chk(tag, bus_obs, BUS_RD);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nt;
        logic prev_tick;

        // Reset values
        cyc();
        chk("rst_tick", tick, 0);
        chk("rst_cnt", tick_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg", cfg_err, 0);
        chk("rst_bus", bus_obs, BUS_IDLE);
        reset_n = 1'b1;
        cyc();

        // period==0 is rejected with a one-cycle cfg_err
        do_start(32'h0, 1'b0, 1'b0);
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_err_busy", busy, 0);
        chk("cfg_err_bus", bus_obs, BUS_IDLE);
        cyc();
        chk("cfg_err_drop", cfg_err, 0);
        chk("cfg_err_bus2", bus_obs, BUS_IDLE);

        // Configure continuous, irq_en
        stat_val = 16'h0002;
        do_start(32'h0001_2345, 1'b1, 1'b1);
        chk("cfg_busy", busy, 1);
        chk("cfg_wr_stop", bus_obs, wr(3'd1, 16'h0008));
        cyc(); chk("cfg_wr_perl", bus_obs, wr(3'd2, 16'h2345));
        cyc(); chk("cfg_wr_perh", bus_obs, wr(3'd3, 16'h0001));
        cyc(); chk("cfg_wr_ctrl", bus_obs, wr(3'd1, 16'h0007));
        cyc(); chk("cfg_run_bus", bus_obs, BUS_IDLE);
        chk("cfg_run_busy", busy, 1);

        // Continuous service: every 3rd poll reports a timeout
        nt = 0;
        prev_tick = 1'b0;
        for (int p = 0; p < 12 && nt < 3; p++) begin
            wait_read("cont_read", 40, n);
            chk("cont_gap", n, prev_tick ? 17 : 16);
            stat_val = (p % 3 == 2) ? 16'h0003 : 16'h0002;
            cyc();
            chk("cont_chk_bus", bus_obs, BUS_IDLE);
            chk("cont_chk_tick", tick, 0);
            cyc();
            if (p % 3 == 2) begin
                nt++;
                chk("cont_clr_bus", bus_obs, wr(3'd0, 16'h0000));
                chk("cont_tick", tick, 1);
                chk("cont_cnt", tick_count, nt);
                prev_tick = 1'b1;
            end else begin
                chk("cont_wait_bus", bus_obs, BUS_IDLE);
                chk("cont_no_tick", tick, 0);
                chk("cont_cnt_hold", tick_count, nt);
                prev_tick = 1'b0;
            end
        end
        chk("cont_ticks", nt, 3);

        // Stop in RUN_WAIT
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_halt", bus_obs, wr(3'd1, 16'h0008));
        chk("stop_busy1", busy, 1);
        cyc();
        chk("stop_busy0", busy, 0);
        chk("stop_bus", bus_obs, BUS_IDLE);
        chk("stop_cnt", tick_count, 3);

        // One-shot with timeout
        stat_val = 16'h0001;
        do_start(32'h0000_0005, 1'b0, 1'b0);
        chk("os_cnt_clr", tick_count, 0);
        cyc(); cyc(); cyc();
        chk("os_wr_ctrl", bus_obs, wr(3'd1, 16'h0004));
        cyc();
        wait_read("os_read", 40, n);
        chk("os_gap", n, 16);
        cyc();
        cyc();
        chk("os_clr_bus", bus_obs, wr(3'd0, 16'h0000));
        chk("os_tick", tick, 1);
        chk("os_cnt", tick_count, 1);
        cyc();
        chk("os_idle_busy", busy, 0);
        chk("os_idle_bus", bus_obs, BUS_IDLE);
        chk("os_idle_tick", tick, 0);

        // start+stop together in IDLE: nothing happens
        period = 32'h10; start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_bus", bus_obs, BUS_IDLE);
        chk("ss_cnt", tick_count, 1);
        period = 32'h0; start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("ss_cfg_err", cfg_err, 0);
        chk("ss_busy2", busy, 0);

        // One-shot already consumed: status 0 returns to IDLE, no tick
        stat_val = 16'h0000;
        do_start(32'h0000_0009, 1'b0, 1'b0);
        cyc(); cyc(); cyc(); cyc();
        wait_read("os0_read", 40, n);
        cyc();
        chk("os0_chk_busy", busy, 1);
        cyc();
        chk("os0_busy", busy, 0);
        chk("os0_tick", tick, 0);
        chk("os0_bus", bus_obs, BUS_IDLE);
        chk("os0_cnt", tick_count, 0);

        // IRQ path, then tick_count wrap
        stat_val = 16'h0003;
        do_start(32'h0000_0100, 1'b1, 1'b1);
        cyc(); cyc(); cyc(); cyc();
        chk("irq_run_bus", bus_obs, BUS_IDLE);
        cyc(); cyc();
        timer_irq = 1'b1;
        cyc();
        timer_irq = 1'b0;
        chk("irq_read", bus_obs, BUS_RD);
        cyc();
        chk("irq_chk_bus", bus_obs, BUS_IDLE);
        cyc();
        chk("irq_clr_bus", bus_obs, wr(3'd0, 16'h0000));
        chk("irq_tick", tick, 1);
        chk("irq_cnt", tick_count, 1);
        dut.tick_cnt_q = 16'hFFFE;
        cyc();
        timer_irq = 1'b1;
        cyc(); cyc(); cyc();
        chk("wrap_tick1", tick, 1);
        chk("wrap_ffff", tick_count, 16'hFFFF);
        cyc(); cyc(); cyc(); cyc();
        chk("wrap_tick2", tick, 1);
        chk("wrap_zero", tick_count, 16'h0000);
        timer_irq = 1'b0;
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("irq_halt", bus_obs, wr(3'd1, 16'h0008));
        cyc();
        chk("irq_idle", busy, 0);

        // Stop during setup at WR_PERL
        do_start(32'h0000_0042, 1'b1, 1'b0);
        cyc();
        chk("sset_perl", bus_obs, wr(3'd2, 16'h0042));
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("sset_halt", bus_obs, wr(3'd1, 16'h0008));
        cyc();
        chk("sset_idle_busy", busy, 0);
        chk("sset_idle_bus", bus_obs, BUS_IDLE);

        // Asynchronous reset in WR_PERH
        stat_val = 16'h0003;
        do_start(32'hABCD_1234, 1'b1, 1'b1);
        cyc(); cyc();
        chk("ar_perh", bus_obs, wr(3'd3, 16'hABCD));
        reset_n = 1'b0;
        #1;
        chk("ar_bus", bus_obs, BUS_IDLE);
        chk("ar_busy", busy, 0);
        chk("ar_tick", tick, 0);
        chk("ar_cnt", tick_count, 0);
        chk("ar_cfg", cfg_err, 0);
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("ar_after_busy", busy, 0);
        chk("ar_after_bus", bus_obs, BUS_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
